// File: rtl/ipif_param_pkg.sv
// ============================================================================
// Module      : ipif_param_pkg
// Description : Shared constants, word type and byte-strobe merge for the
//               IPIF parameter shadow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ipif_param_pkg;

   localparam int COMMIT_CNT_W   = 16;
   localparam int DEFAULT_DATA_W = 32;

   typedef logic [DEFAULT_DATA_W-1:0]   word_t;
   typedef logic [DEFAULT_DATA_W/8-1:0] strb_t;

   function automatic word_t apply_strb(input word_t old_w, input word_t new_w, input strb_t strb);
      word_t res;
      res = old_w;
      for (int b = 0; b < DEFAULT_DATA_W/8; b++) begin
         if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ipif_status_snapshot.sv
// ============================================================================
// Module      : ipif_status_snapshot
// Description : Snapshot bank and read port for multi-word IP status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ipif_status_snapshot
   import ipif_param_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int N_STAT = 2,
   parameter int RA_W   = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     rd_en_i,
   input  logic [RA_W-1:0]          rd_addr_i,
   input  logic [N_STAT*DATA_W-1:0] status_i,
   output logic [DATA_W-1:0]        rd_data_o,
   output logic                     rd_valid_o
);

   logic [N_STAT*DATA_W-1:0] snap_q, snap_d;
   logic [DATA_W-1:0]        data_q, data_d;
   logic                     valid_q, valid_d;

   // Reading word 0 freezes every status word so later words match it.
   always_comb begin
      snap_d  = snap_q;
      data_d  = data_q;
      valid_d = rd_en_i;
      if (rd_en_i) begin
         data_d = '0;
         if (rd_addr_i == '0) begin
            snap_d = status_i;
            data_d = status_i[DATA_W-1:0];
         end else begin
            for (int k = 1; k < N_STAT; k++) begin
               if (32'(rd_addr_i) == k) data_d = snap_q[k*DATA_W +: DATA_W];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         snap_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         snap_q  <= snap_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign rd_data_o  = data_q;
   assign rd_valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/ipif_param_shadow.sv
// ============================================================================
// Module      : ipif_param_shadow
// Description : Staged/active control-word shadow with atomic commit, dirty
//               tracking, commit counting and snapshot status reads.
//               Optional macro IPIF_PARAM_AUTOCOMMIT_EN: a write to the last
//               control word also commits, including that write's data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ipif_param_shadow
   import ipif_param_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int N_REG  = 4,
   parameter int N_STAT = 2,
   parameter logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] RESET_VALUE = '0,
   localparam int WA_W = (N_REG  > 1) ? $clog2(N_REG)  : 1,
   localparam int RA_W = (N_STAT > 1) ? $clog2(N_STAT) : 1
) (
   input  logic                                 IP_clk,
   input  logic                                 IP_rst,
   input  logic                                 wr_en,
   input  logic [WA_W-1:0]                      wr_addr,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]        wr_data,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      wr_strb,
   input  logic                                 commit,
   output logic [N_REG*C_S_AXI_DATA_WIDTH-1:0]  params_to_IP,
   output logic                                 params_update,
   output logic [N_REG-1:0]                     dirty,
   output logic [COMMIT_CNT_W-1:0]              commit_count,
   input  logic [N_STAT*C_S_AXI_DATA_WIDTH-1:0] status_from_IP,
   input  logic                                 rd_en,
   input  logic [RA_W-1:0]                      rd_addr,
   output logic [C_S_AXI_DATA_WIDTH-1:0]        rd_data,
   output logic                                 rd_valid
);

   localparam int W  = C_S_AXI_DATA_WIDTH;
   localparam int BW = W/8;

   logic [N_REG*W-1:0]      staged_q, staged_d, active_q, active_d;
   logic [N_REG-1:0]        dirty_q, dirty_d, wr_mask;
   logic [COMMIT_CNT_W-1:0] count_q, count_d;
   logic                    update_q, update_d;
   logic                    auto_commit, do_commit;
   logic [W-1:0]            old_word, merged_word;

   generate
      if (W == DEFAULT_DATA_W) begin : g_pkg_merge
         assign merged_word = apply_strb(old_word, wr_data, wr_strb);
      end else begin : g_loop_merge
         always_comb begin
            merged_word = old_word;
            for (int b = 0; b < BW; b++) begin
               if (wr_strb[b]) merged_word[b*8 +: 8] = wr_data[b*8 +: 8];
            end
         end
      end
   endgenerate

   // Out-of-range addresses leave wr_mask empty, so the write is dropped.
   always_comb begin
      wr_mask  = '0;
      old_word = '0;
      for (int k = 0; k < N_REG; k++) begin
         if (32'(wr_addr) == k) begin
            wr_mask[k] = wr_en;
            old_word   = staged_q[k*W +: W];
         end
      end

      staged_d = staged_q;
      for (int k = 0; k < N_REG; k++) begin
         if (wr_mask[k]) staged_d[k*W +: W] = merged_word;
      end

`ifdef IPIF_PARAM_AUTOCOMMIT_EN
      auto_commit = wr_mask[N_REG-1];
`else
      auto_commit = 1'b0;
`endif
      do_commit = auto_commit || (commit && (dirty_q != '0));

      active_d = active_q;
      dirty_d  = dirty_q | wr_mask;
      count_d  = count_q;
      update_d = 1'b0;
      // A plain commit transfers the pre-write bank; a concurrent write stays dirty.
      if (do_commit) begin
         active_d = auto_commit ? staged_d : staged_q;
         dirty_d  = auto_commit ? '0 : wr_mask;
         count_d  = count_q + 1'b1;
         update_d = 1'b1;
      end
   end

   always_ff @(posedge IP_clk) begin
      if (IP_rst) begin
         staged_q <= RESET_VALUE;
         active_q <= RESET_VALUE;
         dirty_q  <= '0;
         count_q  <= '0;
         update_q <= 1'b0;
      end else begin
         staged_q <= staged_d;
         active_q <= active_d;
         dirty_q  <= dirty_d;
         count_q  <= count_d;
         update_q <= update_d;
      end
   end

   assign params_to_IP  = active_q;
   assign params_update = update_q;
   assign dirty         = dirty_q;
   assign commit_count  = count_q;

   ipif_status_snapshot #(
      .DATA_W (W),
      .N_STAT (N_STAT),
      .RA_W   (RA_W)
   ) u_snapshot (
      .clk_i      (IP_clk),
      .rst_i      (IP_rst),
      .rd_en_i    (rd_en),
      .rd_addr_i  (rd_addr),
      .status_i   (status_from_IP),
      .rd_data_o  (rd_data),
      .rd_valid_o (rd_valid)
   );

endmodule

`default_nettype wire

// File: tb/tb_ipif_param_shadow.sv
// ============================================================================
// Module      : tb_ipif_param_shadow
// Description : Self-checking bench for ipif_param_shadow (scoreboard queues).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ipif_param_shadow;

   localparam int W  = 32;
   localparam int NR = 4;
   localparam int NS = 3;   // three status words so index 3 is out of range
   localparam logic [NR*W-1:0] RV = {32'hA5A5_0003, 32'h0, 32'h0, 32'h1};

   logic              IP_clk = 1'b0;
   logic              IP_rst;
   logic              wr_en;
   logic [1:0]        wr_addr;
   logic [W-1:0]      wr_data;
   logic [W/8-1:0]    wr_strb;
   logic              commit;
   logic [NR*W-1:0]   params_to_IP;
   logic              params_update;
   logic [NR-1:0]     dirty;
   logic [15:0]       commit_count;
   logic [NS*W-1:0]   status_from_IP;
   logic              rd_en;
   logic [1:0]        rd_addr;
   logic [W-1:0]      rd_data;
   logic              rd_valid;

   int checks = 0;
   int errors = 0;

   logic [NR*W-1:0] q_par[$];
   logic [W-1:0]    q_rd[$];
   logic [NR*W-1:0] exp_act;
   logic [NR*W-1:0] exp_p;
   logic [W-1:0]    exp_r;
   logic [15:0]     exp_cnt;

   ipif_param_shadow #(
      .C_S_AXI_DATA_WIDTH (W),
      .N_REG              (NR),
      .N_STAT             (NS),
      .RESET_VALUE        (RV)
   ) dut (
      .IP_clk         (IP_clk),
      .IP_rst         (IP_rst),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .wr_strb        (wr_strb),
      .commit         (commit),
      .params_to_IP   (params_to_IP),
      .params_update  (params_update),
      .dirty          (dirty),
      .commit_count   (commit_count),
      .status_from_IP (status_from_IP),
      .rd_en          (rd_en),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data),
      .rd_valid       (rd_valid)
   );

   always #5 IP_clk = ~IP_clk;

   task automatic step();
      @(posedge IP_clk);
      #1;
   endtask

   task automatic idle();
      wr_en   = 1'b0;
      commit  = 1'b0;
      rd_en   = 1'b0;
      wr_strb = '0;
   endtask

   task automatic test_reset();
      IP_rst = 1'b1;
      wr_en = 1'b1; wr_addr = 2'd3; wr_data = '1; wr_strb = '1;
      commit = 1'b1; rd_en = 1'b1; rd_addr = 2'd0;
      status_from_IP = {32'h3, 32'h2, 32'h1};
      step(); step();
      IP_rst = 1'b0;
      idle();
      q_par.push_back(RV);
      exp_act = RV;
      exp_cnt = 16'h0;
      checks++; exp_p = q_par.pop_front();
      if (params_to_IP !== exp_p) begin errors++; $display("FAIL reset_params actual=%h expected=%h", params_to_IP, exp_p); end
      checks++;
      if (dirty !== 4'b0000) begin errors++; $display("FAIL reset_dirty actual=%b expected=0000", dirty); end
      checks++;
      if (commit_count !== 16'h0) begin errors++; $display("FAIL reset_count actual=%h expected=0000", commit_count); end
      checks++;
      if (params_update !== 1'b0) begin errors++; $display("FAIL reset_update actual=%b expected=0", params_update); end
      checks++;
      if (rd_valid !== 1'b0 || rd_data !== '0) begin errors++; $display("FAIL reset_read actual=%b/%h expected=0/0", rd_valid, rd_data); end
   endtask

   task automatic test_partial_strobe();
      wr_en = 1'b1; wr_addr = 2'd1; wr_data = 32'h1234_5678; wr_strb = 4'b0011;
      step(); idle();
      checks++;
      if (dirty !== 4'b0010) begin errors++; $display("FAIL strb_dirty actual=%b expected=0010", dirty); end
      checks++;
      if (params_to_IP !== exp_act) begin errors++; $display("FAIL strb_no_leak actual=%h expected=%h", params_to_IP, exp_act); end
      commit = 1'b1;
      exp_act[1*W +: W] = 32'h0000_5678;
      q_par.push_back(exp_act);
      exp_cnt++;
      step(); idle();
      checks++; exp_p = q_par.pop_front();
      if (params_to_IP !== exp_p) begin errors++; $display("FAIL strb_commit actual=%h expected=%h", params_to_IP, exp_p); end
      checks++;
      if (params_update !== 1'b1) begin errors++; $display("FAIL strb_update actual=%b expected=1", params_update); end
      checks++;
      if (commit_count !== exp_cnt) begin errors++; $display("FAIL strb_count actual=%h expected=%h", commit_count, exp_cnt); end
      checks++;
      if (dirty !== 4'b0000) begin errors++; $display("FAIL strb_dirty_clr actual=%b expected=0000", dirty); end
      step();
      checks++;
      if (params_update !== 1'b0) begin errors++; $display("FAIL strb_pulse_width actual=%b expected=0", params_update); end
   endtask

   task automatic test_empty_commit();
      commit = 1'b1;
      step(); idle();
      checks++;
      if (params_update !== 1'b0) begin errors++; $display("FAIL empty_update actual=%b expected=0", params_update); end
      checks++;
      if (commit_count !== exp_cnt) begin errors++; $display("FAIL empty_count actual=%h expected=%h", commit_count, exp_cnt); end
   endtask

   task automatic test_write_and_commit();
      wr_en = 1'b1; wr_addr = 2'd2; wr_data = 32'h11; wr_strb = 4'hF;
      step();
      checks++;
      if (dirty !== 4'b0100) begin errors++; $display("FAIL wc_dirty_pre actual=%b expected=0100", dirty); end
      wr_data = 32'h22; commit = 1'b1;
      exp_act[2*W +: W] = 32'h11;
      q_par.push_back(exp_act);
      exp_cnt++;
      step(); idle();
      checks++; exp_p = q_par.pop_front();
      if (params_to_IP !== exp_p) begin errors++; $display("FAIL wc_active actual=%h expected=%h", params_to_IP, exp_p); end
      checks++;
      if (dirty !== 4'b0100) begin errors++; $display("FAIL wc_dirty_kept actual=%b expected=0100", dirty); end
      checks++;
      if (params_update !== 1'b1 || commit_count !== exp_cnt) begin
         errors++; $display("FAIL wc_pulse_count actual=%b/%h expected=1/%h", params_update, commit_count, exp_cnt);
      end
      commit = 1'b1;
      exp_act[2*W +: W] = 32'h22;
      q_par.push_back(exp_act);
      exp_cnt++;
      step(); idle();
      checks++; exp_p = q_par.pop_front();
      if (params_to_IP !== exp_p) begin errors++; $display("FAIL wc_second actual=%h expected=%h", params_to_IP, exp_p); end
      checks++;
      if (dirty !== 4'b0000 || commit_count !== exp_cnt) begin
         errors++; $display("FAIL wc_second_state actual=%b/%h expected=0000/%h", dirty, commit_count, exp_cnt);
      end
   endtask

   task automatic test_snapshot();
      logic [1:0]   addrs [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
      logic [W-1:0] exps  [4] = '{32'hA, 32'hB, 32'hE, 32'h0};
      bit           seen;
      status_from_IP = {32'hE, 32'hB, 32'hA};
      for (int i = 0; i < 4; i++) begin
         rd_en = 1'b1; rd_addr = addrs[i];
         q_rd.push_back(exps[i]);
         step();
         rd_en = 1'b0;
         if (i == 0) status_from_IP = {32'hF, 32'hD, 32'hC};
         seen = rd_valid;
         for (int n = 0; n < 4 && !seen; n++) begin
            step();
            seen = rd_valid;
         end
         checks++;
         if (!seen) begin
            errors++; $display("FAIL snap_timeout_%0d actual=no_valid expected=valid", i);
            void'(q_rd.pop_front());
         end else begin
            exp_r = q_rd.pop_front();
            if (rd_data !== exp_r) begin errors++; $display("FAIL snap_data_%0d actual=%h expected=%h", i, rd_data, exp_r); end
         end
         step();
         checks++;
         if (rd_valid !== 1'b0 || rd_data !== exps[i]) begin
            errors++; $display("FAIL snap_hold_%0d actual=%b/%h expected=0/%h", i, rd_valid, rd_data, exps[i]);
         end
      end
   endtask

   task automatic test_count_wrap();
      int n;
      wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'hFFFF_FFFF; wr_strb = 4'b0000;
      step();
      commit = 1'b1;
      n = int'(16'hFFFF - exp_cnt);
      for (int i = 0; i < n; i++) step();
      exp_cnt = 16'hFFFF;
      checks++;
      if (commit_count !== exp_cnt) begin errors++; $display("FAIL wrap_preload actual=%h expected=%h", commit_count, exp_cnt); end
      wr_en = 1'b0;
      exp_cnt++;
      q_par.push_back(exp_act);
      step(); idle();
      checks++;
      if (commit_count !== 16'h0000 || params_update !== 1'b1) begin
         errors++; $display("FAIL wrap_zero actual=%h/%b expected=0000/1", commit_count, params_update);
      end
      checks++; exp_p = q_par.pop_front();
      if (params_to_IP !== exp_p || dirty !== 4'b0000) begin
         errors++; $display("FAIL wrap_state actual=%h/%b expected=%h/0000", params_to_IP, dirty, exp_p);
      end
   endtask

   task automatic test_autocommit();
      wr_en = 1'b1; wr_addr = 2'd3; wr_data = 32'hCAFE_F00D; wr_strb = 4'b1100;
`ifdef IPIF_PARAM_AUTOCOMMIT_EN
      exp_act[3*W +: W] = 32'hCAFE_0003;
      q_par.push_back(exp_act);
      exp_cnt++;
      step(); idle();
      checks++; exp_p = q_par.pop_front();
      if (params_to_IP !== exp_p) begin errors++; $display("FAIL auto_active actual=%h expected=%h", params_to_IP, exp_p); end
      checks++;
      if (params_update !== 1'b1 || dirty !== 4'b0000 || commit_count !== exp_cnt) begin
         errors++; $display("FAIL auto_state actual=%b/%b/%h expected=1/0000/%h", params_update, dirty, commit_count, exp_cnt);
      end
`else
      q_par.push_back(exp_act);
      step(); idle();
      checks++; exp_p = q_par.pop_front();
      if (params_to_IP !== exp_p || params_update !== 1'b0) begin
         errors++; $display("FAIL last_no_auto actual=%h/%b expected=%h/0", params_to_IP, params_update, exp_p);
      end
      checks++;
      if (dirty !== 4'b1000) begin errors++; $display("FAIL last_dirty actual=%b expected=1000", dirty); end
      commit = 1'b1;
      exp_act[3*W +: W] = 32'hCAFE_0003;
      q_par.push_back(exp_act);
      exp_cnt++;
      step(); idle();
      checks++; exp_p = q_par.pop_front();
      if (params_to_IP !== exp_p || commit_count !== exp_cnt) begin
         errors++; $display("FAIL last_commit actual=%h/%h expected=%h/%h", params_to_IP, commit_count, exp_p, exp_cnt);
      end
`endif
   endtask

   initial begin
      IP_rst = 1'b1;
      wr_addr = '0; wr_data = '0; rd_addr = '0;
      status_from_IP = '0;
      idle();
      test_reset();
      test_partial_strobe();
      test_empty_commit();
      test_write_and_commit();
      test_snapshot();
      test_count_wrap();
      test_autocommit();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
